seg7_counter_mux: RTL and testbench

Parametrised multi-digit up/down counter with a time-multiplexed common-anode 7-segment display driver.
- Counts in hex or BCD; supports enable, direction, parallel load, wrap flag and leading-zero blanking.
- Digit count, count rate, scan rate and output polarity are set by parameters.
- Sits between board buttons/switches and the display pins; the next generation of the fixed 4-digit prescaled hex counter.

---
 rtl/seg7_pkg.sv | 26 ++
 rtl/seg7_decoder.sv | 21 ++
 rtl/seg7_counter_mux.sv | 142 ++++++++++++++
 tb/tb_seg7_counter_mux.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment display blocks.
// Glyphs are active-low {a,b,c,d,e,f,g,dp}.
package seg7_pkg;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  localparam int RADIX_DEC = 10;
  localparam int RADIX_HEX = 16;

  // Index 15 first: F E d C b A 9 8 7 6 5 4 3 2 1 0
  localparam logic [15:0][7:0] GLYPHS = {
    8'h71, 8'h61, 8'h85, 8'h63,
    8'hC1, 8'h11, 8'h09, 8'h01,
    8'h1F, 8'h41, 8'h49, 8'h99,
    8'h0D, 8'h25, 8'h9F, 8'h03
  };

  // Bits needed to hold 0..v-1, never less than 1.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Nibble to 7-segment glyph with blanking and
// output polarity selection; purely combinational.
module seg7_decoder
  import seg7_pkg::*;
#(
  parameter int ACTIVE_LOW = 1
) (
  input  logic [3:0] nib,
  input  logic       blank,
  output logic [7:0] seg
);

  logic [7:0] raw;

  // Look up the glyph, then flip for active-high boards.
  always_comb begin
    raw = blank ? SEG_OFF : GLYPHS[nib];
    seg = (ACTIVE_LOW != 0) ? raw : ~raw;
  end

endmodule

// File: rtl/seg7_counter_mux.sv
// Multi-digit hex/BCD up/down counter driving a
// time-multiplexed 7-segment display.
module seg7_counter_mux
  import seg7_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int TICK_DIV   = 33554432,
  parameter int SCAN_DIV   = 131072,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up,
  input  logic                  mode_dec,
  input  logic                  blank_lz,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  wrap,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     an
);

  localparam int TW = clog2(TICK_DIV);
  localparam int SW = clog2(SCAN_DIV);
  localparam int IW = clog2(DIGITS);

  localparam logic [TW-1:0] TMAX = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SMAX = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IMAX = IW'(DIGITS - 1);

  localparam logic [7:0] SEG_RST =
    (ACTIVE_LOW != 0) ? SEG_OFF : ~SEG_OFF;
  localparam logic [DIGITS-1:0] AN_RST =
    (ACTIVE_LOW != 0) ? '1 : '0;

  logic [TW-1:0]     tpre;
  logic [SW-1:0]     spre;
  logic [IW-1:0]     idx;
  logic              tick;
  logic              step;
  logic [3:0]        rmax;
  logic              cy [0:DIGITS];
  logic [3:0]        nib_nx [DIGITS];
  logic [DIGITS-1:0] blank_v;
  logic [3:0]        sel_nib;
  logic [7:0]        seg_nx;
  logic [DIGITS-1:0] an_oh;

  assign tick  = (tpre == TMAX);
  assign step  = tick & en & ~load;
  assign rmax  = mode_dec ? 4'(RADIX_DEC - 1)
                          : 4'(RADIX_HEX - 1);
  assign cy[0] = 1'b1;

  // Per-digit ripple: carry/borrow enters from the digit below.
  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    logic [3:0] d;
    logic [3:0] dc;
    logic       hit;
    assign d   = count[4*i +: 4];
    assign dc  = (mode_dec && d > 4'd9) ? 4'd9 : d;
    assign hit = up ? (mode_dec ? (d >= 4'd9) : (d == 4'hF))
                    : (dc == 4'd0);
    assign cy[i+1]   = cy[i] & hit;
    assign nib_nx[i] = !cy[i] ? d
                     : up    ? (hit ? 4'd0 : d + 4'd1)
                             : (hit ? rmax : dc - 4'd1);
  end

  // Leading-zero mask, scanned from the top digit down.
  always_comb begin
    logic nz;
    nz      = 1'b0;
    blank_v = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nz         = nz | (count[4*i +: 4] != 4'd0);
      blank_v[i] = blank_lz && (i > 0) && !nz;
    end
  end

  assign sel_nib = count[4*idx +: 4];
  assign an_oh   = DIGITS'(1) << idx;

  seg7_decoder #(
    .ACTIVE_LOW(ACTIVE_LOW)
  ) u_dec (
    .nib  (sel_nib),
    .blank(blank_v[idx]),
    .seg  (seg_nx)
  );

  // Count-rate prescaler, free running.
  always_ff @(posedge clk) begin
    if (reset)     tpre <= '0;
    else if (tick) tpre <= '0;
    else           tpre <= tpre + 1'b1;
  end

  // Scan prescaler and digit index.
  always_ff @(posedge clk) begin
    if (reset) begin
      spre <= '0;
      idx  <= '0;
    end else if (spre == SMAX) begin
      spre <= '0;
      idx  <= (idx == IMAX) ? '0 : idx + 1'b1;
    end else begin
      spre <= spre + 1'b1;
    end
  end

  // Counter value and wrap pulse; load beats a step.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      wrap  <= 1'b0;
    end else if (load) begin
      count <= load_val;
      wrap  <= 1'b0;
    end else if (step) begin
      for (int i = 0; i < DIGITS; i++)
        count[4*i +: 4] <= nib_nx[i];
      wrap <= cy[DIGITS];
    end else begin
      wrap <= 1'b0;
    end
  end

  // Registered display outputs, one cycle behind idx/count.
  always_ff @(posedge clk) begin
    if (reset) begin
      seg <= SEG_RST;
      an  <= AN_RST;
    end else begin
      seg <= seg_nx;
      an  <= (ACTIVE_LOW != 0) ? ~an_oh : an_oh;
    end
  end

endmodule

// File: tb/tb_seg7_counter_mux.sv
// Directed bench for seg7_counter_mux, active-low and
// active-high builds side by side on shared inputs.
module tb_seg7_counter_mux;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic        up = 1'b1;
  logic        mode_dec = 1'b0;
  logic        blank_lz = 1'b0;
  logic        load = 1'b0;
  logic [15:0] load_val = 16'h0;

  logic [15:0] count, count_h;
  logic        wrap, wrap_h;
  logic [7:0]  seg, seg_h;
  logic [3:0]  an, an_h;

  int n_chk = 0;
  int n_fail = 0;
  int k = 0;

  always #5 clk = ~clk;

  seg7_counter_mux #(
    .DIGITS(4), .TICK_DIV(4), .SCAN_DIV(2), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .up(up),
    .mode_dec(mode_dec), .blank_lz(blank_lz),
    .load(load), .load_val(load_val),
    .count(count), .wrap(wrap), .seg(seg), .an(an)
  );

  seg7_counter_mux #(
    .DIGITS(4), .TICK_DIV(4), .SCAN_DIV(2), .ACTIVE_LOW(0)
  ) dut_h (
    .clk(clk), .reset(reset), .en(en), .up(up),
    .mode_dec(mode_dec), .blank_lz(blank_lz),
    .load(load), .load_val(load_val),
    .count(count_h), .wrap(wrap_h), .seg(seg_h), .an(an_h)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
    k++;
  endtask

  // Next edge k with k%4==0 carries a tick.
  task automatic tick_step();
    while ((k + 1) % 4 != 0) cyc();
    cyc();
  endtask

  task automatic do_load(input logic [15:0] v);
    load_val = v;
    load = 1'b1;
    cyc();
    load = 1'b0;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  logic [7:0] exp50 [4];
  logic [7:0] exp00 [4];
  int e;

  initial begin
    exp50 = '{8'h03, 8'h49, 8'hFF, 8'hFF};
    exp00 = '{8'h03, 8'hFF, 8'hFF, 8'hFF};

    // 1: reset and scan walk
    repeat (3) cyc();
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_wrap", 32'(wrap), 32'h0);
    chk("rst_seg", 32'(seg), 32'hFF);
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_seg_h", 32'(seg_h), 32'h00);
    chk("rst_an_h", 32'(an_h), 32'h0);
    reset = 1'b0;
    k = 0;
    cyc();
    chk("scan_an0", 32'(an), 32'hE);
    chk("scan_seg0", 32'(seg), 32'h03);
    cyc(); cyc();
    chk("scan_an1", 32'(an), 32'hD);
    cyc(); cyc();
    chk("scan_an2", 32'(an), 32'hB);
    cyc(); cyc();
    chk("scan_an3", 32'(an), 32'h7);
    cyc(); cyc();
    chk("scan_an_back", 32'(an), 32'hE);

    // 2: hex up across FFFF, then down across 0000
    en = 1'b1; up = 1'b1; mode_dec = 1'b0;
    do_load(16'hFFFE);
    chk("hex_load", 32'(count), 32'hFFFE);
    chk("hex_load_wrap", 32'(wrap), 32'h0);
    tick_step();
    chk("hex_ffff", 32'(count), 32'hFFFF);
    chk("hex_ffff_wrap", 32'(wrap), 32'h0);
    tick_step();
    chk("hex_0000", 32'(count), 32'h0000);
    chk("hex_wrap", 32'(wrap), 32'h1);
    cyc();
    chk("hex_wrap_1cyc", 32'(wrap), 32'h0);
    chk("hex_hold", 32'(count), 32'h0000);
    up = 1'b0;
    tick_step();
    chk("hex_dn_ffff", 32'(count), 32'hFFFF);
    chk("hex_dn_wrap", 32'(wrap), 32'h1);

    // 3: BCD down and up
    mode_dec = 1'b1;
    do_load(16'h1000);
    tick_step();
    chk("bcd_0999", 32'(count), 32'h0999);
    chk("bcd_0999_wrap", 32'(wrap), 32'h0);
    do_load(16'h0000);
    tick_step();
    chk("bcd_9999", 32'(count), 32'h9999);
    chk("bcd_wrap", 32'(wrap), 32'h1);
    up = 1'b1;
    do_load(16'h0999);
    tick_step();
    chk("bcd_up_1000", 32'(count), 32'h1000);
    chk("bcd_up_wrap", 32'(wrap), 32'h0);

    // en=0 holds through a tick
    en = 1'b0;
    tick_step();
    chk("en_hold", 32'(count), 32'h1000);

    // 4: load lands on a tick cycle
    en = 1'b1; mode_dec = 1'b0; up = 1'b1;
    while ((k + 1) % 4 != 0) cyc();
    do_load(16'h1234);
    chk("coll_load", 32'(count), 32'h1234);
    tick_step();
    chk("coll_next", 32'(count), 32'h1235);

    // 5: leading-zero blanking
    en = 1'b0; blank_lz = 1'b1;
    do_load(16'h0050);
    cyc();
    for (int j = 0; j < 8; j++) begin
      cyc();
      e = ((k - 1) / 2) % 4;
      chk($sformatf("blank50_seg%0d", e), 32'(seg), 32'(exp50[e]));
      chk($sformatf("blank50_an%0d", e), 32'(an),
          32'(4'hF & ~(4'h1 << e)));
    end
    do_load(16'h0000);
    cyc();
    for (int j = 0; j < 8; j++) begin
      cyc();
      e = ((k - 1) / 2) % 4;
      chk($sformatf("blank00_seg%0d", e), 32'(seg), 32'(exp00[e]));
    end

    // 6: active-high build showing an 8
    blank_lz = 1'b0;
    do_load(16'h0008);
    cyc();
    for (int j = 0; j < 8; j++) begin
      cyc();
      e = ((k - 1) / 2) % 4;
      chk($sformatf("ah_seg%0d", e), 32'(seg_h),
          (e == 0) ? 32'hFE : 32'hFC);
      chk($sformatf("ah_an%0d", e), 32'(an_h), 32'(4'h1 << e));
    end

    // 6: reset while running with index 2 selected
    blank_lz = 1'b1;
    do_load(16'h0A3C);
    for (int j = 0; j < 8 && (k / 2) % 4 != 2; j++) cyc();
    chk("pre_rst_count", 32'(count), 32'h0A3C);
    en = 1'b1;
    reset = 1'b1;
    cyc();
    k = 0;
    chk("mid_rst_count", 32'(count), 32'h0);
    chk("mid_rst_wrap", 32'(wrap), 32'h0);
    chk("mid_rst_seg", 32'(seg), 32'hFF);
    chk("mid_rst_an", 32'(an), 32'hF);
    chk("mid_rst_seg_h", 32'(seg_h), 32'h00);
    chk("mid_rst_an_h", 32'(an_h), 32'h0);
    en = 1'b0;
    reset = 1'b0;
    cyc();
    chk("post_rst_an", 32'(an), 32'hE);
    chk("post_rst_seg", 32'(seg), 32'h03);
    chk("post_rst_an_h", 32'(an_h), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
